// File: rtl/mash_ncl.sv
// MASH 1-1-1 recombination network: aligns three stage carries, applies the
// (1-z^-1) differentiators and adds the integer base with saturation.
// Latency 0 from c3 (1 sample with MASH_NCL_OUTREG_EN); state advances only on en.
module mash_ncl #(
  parameter int nw    = 8,
  parameter int order = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic signed [1:0]    c1,
  input  logic signed [1:0]    c2,
  input  logic signed [1:0]    c3,
  input  logic        [nw-1:0] n_int,
  output logic        [nw-1:0] div_out,
  output logic signed [3:0]    y_out,
  output logic                 out_vld,
  output logic                 sat
);

  // Fill count at which every delay tap used by this order holds a real sample.
  localparam logic [1:0] FILL_LAST = 2'(order - 1);

  logic signed [1:0] c1d1_q, c1d2_q;
  logic signed [1:0] c2d1_q, c2d2_q;
  logic signed [1:0] c3d1_q, c3d2_q;
  logic        [1:0] cnt_q, cnt_d;

  logic signed [3:0]    y_c;
  logic signed [nw+1:0] s_c;
  logic        [nw-1:0] div_c;
  logic                 sat_c;
  logic                 vld_c;

  function automatic logic signed [3:0] sx(input logic signed [1:0] v);
    return {{2{v[1]}}, v};
  endfunction

  // Alignment delays for c1/c2 plus history taps for the differentiators.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c1d1_q <= '0;
      c1d2_q <= '0;
      c2d1_q <= '0;
      c2d2_q <= '0;
      c3d1_q <= '0;
      c3d2_q <= '0;
    end else if (en) begin
      c1d1_q <= c1;
      c1d2_q <= c1d1_q;
      c2d1_q <= c2;
      c2d2_q <= c2d1_q;
      c3d1_q <= c3;
      c3d2_q <= c3d1_q;
    end
  end

  // Fill counter: counts enabled samples until the delay lines are primed.
  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q < FILL_LAST)) cnt_d = cnt_q + 2'd1;
  end

  // Fill counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign vld_c = (cnt_q == FILL_LAST);

  // Recombination; range [-3,+4] always fits 4-bit signed.
  always_comb begin
    y_c = '0;
    if (order == 1) begin
      y_c = sx(c1);
    end else if (order == 2) begin
      y_c = sx(c1d1_q) + (sx(c2) - sx(c2d1_q));
    end else begin
      y_c = sx(c1d2_q) + (sx(c2d1_q) - sx(c2d2_q))
          + (sx(c3) - (sx(c3d1_q) <<< 1) + sx(c3d2_q));
    end
  end

  // Base plus fractional term, clipped to the unsigned nw-bit divider range.
  always_comb begin
    s_c   = signed'({2'b00, n_int}) + signed'({{(nw-2){y_c[3]}}, y_c});
    div_c = s_c[nw-1:0];
    sat_c = 1'b0;
    if (s_c[nw+1]) begin
      div_c = '0;
      sat_c = 1'b1;
    end else if (s_c[nw]) begin
      div_c = '1;
      sat_c = 1'b1;
    end
  end

`ifdef MASH_NCL_OUTREG_EN
  logic        [nw-1:0] div_q;
  logic signed [3:0]    y_q;
  logic                 sat_q;
  logic                 vld_q;

  // Output stage: captures each enabled sample, one sample behind.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
      vld_q <= 1'b0;
    end else if (en) begin
      div_q <= div_c;
      y_q   <= y_c;
      sat_q <= sat_c;
      vld_q <= vld_c;
    end
  end

  assign div_out = div_q;
  assign y_out   = y_q;
  assign sat     = sat_q;
  assign out_vld = vld_q;
`else
  assign div_out = div_c;
  assign y_out   = y_c;
  assign sat     = sat_c;
  assign out_vld = vld_c;
`endif

endmodule
